// File: rtl/pipe_skid_chain.sv
// -----------------------------------------------------------------------------
// pipe_skid_chain
//
// Purpose
//   Register pipeline of STAGES skid-buffered stages carrying a WIDTH-bit
//   payload with a valid/ready handshake. It breaks long timing paths between
//   a producer and a consumer in one clock domain. It keeps full throughput and
//   never drops or duplicates a beat.
//
//   Each stage has a main register (m) and a skid register (s). A stage's ready
//   is simply ~s_v, which is a flop output. As a result, out_ready never reaches
//   in_ready through combinational logic.
//
// Parameters
//   WIDTH   payload width in bits (>=1)
//   STAGES  number of skid stages in series (>=1)
//   CNT_W   occupancy counter width, derived from STAGES (do not override)
//
// Ports
//   clk        in   clock, all state updates on posedge
//   reset      in   asynchronous, active-high reset
//   flush      in   synchronous flush (only when PIPE_FLUSH_EN is defined)
//   in_valid   in   producer beat valid
//   in_data    in   producer payload
//   in_ready   out  chain can accept a beat this cycle
//   out_valid  out  consumer beat valid
//   out_data   out  consumer payload (holds last value while out_valid=0)
//   out_ready  in   consumer accepts beat this cycle
//   count      out  beats currently held in the chain (0..2*STAGES)
//
// Build option
//   PIPE_FLUSH_EN  when defined, adds the `flush` input. A flush clears every
//                  valid flag and the count at the next posedge. The data
//                  registers keep their values, and a beat offered in the
//                  flush cycle is discarded.
// -----------------------------------------------------------------------------
module pipe_skid_chain #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = $clog2(2*STAGES+1)
) (
  input  logic             clk,
  input  logic             reset,
`ifdef PIPE_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
);

  // Flush request; tied off when the option is not built in.
  logic flush_w;
`ifdef PIPE_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // rdy_en_q keeps in_ready low while reset is asserted. It rises on the first
  // clock edge after reset is released, so the producer never sees a ready
  // that arrived without a clock edge.
  logic rdy_en_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
    end
  end

  // Inter-stage links. Index k is the input side of stage k, and index STAGES
  // is the chain output. chain_rdy[k] is the ready presented by stage k
  // upstream. chain_rdy[STAGES] is the consumer's ready.
  logic [STAGES:0]            chain_v;
  logic [STAGES:0][WIDTH-1:0] chain_d;
  logic [STAGES:0]            chain_rdy;

  assign chain_v[0]         = in_valid;
  assign chain_d[0]         = in_data;
  assign chain_rdy[STAGES]  = out_ready;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      logic             m_v_q, m_v_d;
      logic             s_v_q, s_v_d;
      logic [WIDTH-1:0] m_d_q, m_d_d;
      logic [WIDTH-1:0] s_d_q, s_d_d;
      logic             stg_rdy;
      logic             acc_in;
      logic             acc_out;

      if (gi == 0) begin : g_head
        assign stg_rdy = rdy_en_q & ~s_v_q;
      end else begin : g_body
        assign stg_rdy = ~s_v_q;
      end

      assign chain_rdy[gi] = stg_rdy;

      // Accepts are suppressed during a flush so that the data registers keep
      // their previous contents while the valids are cleared.
      assign acc_in  = chain_v[gi] & stg_rdy & ~flush_w;
      assign acc_out = m_v_q & chain_rdy[gi+1] & ~flush_w;

      always_comb begin
        m_v_d = m_v_q;
        s_v_d = s_v_q;
        m_d_d = m_d_q;
        s_d_d = s_d_q;
        if (acc_out && s_v_q) begin
          // The skid beat moves into main. The stage is not ready while the
          // skid is full, so no new beat can arrive in the same cycle.
          m_d_d = s_d_q;
          s_v_d = 1'b0;
        end else begin
          m_v_d = acc_in | (m_v_q & ~acc_out);
          if (acc_in && m_v_q && !acc_out) begin
            // Main is occupied and stalled, so the new beat parks in the skid.
            s_v_d = 1'b1;
            s_d_d = chain_d[gi];
          end else if (acc_in) begin
            m_d_d = chain_d[gi];
          end
        end
        if (flush_w) begin
          m_v_d = 1'b0;
          s_v_d = 1'b0;
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          m_v_q <= 1'b0;
          s_v_q <= 1'b0;
          m_d_q <= '0;
          s_d_q <= '0;
        end else begin
          m_v_q <= m_v_d;
          s_v_q <= s_v_d;
          m_d_q <= m_d_d;
          s_d_q <= s_d_d;
        end
      end

      assign chain_v[gi+1] = m_v_q;
      assign chain_d[gi+1] = m_d_q;
    end
  endgenerate

  assign in_ready  = chain_rdy[0];
  assign out_valid = chain_v[STAGES];
  assign out_data  = chain_d[STAGES];

  // Occupancy counter tracks the port-level handshakes.
  logic             in_xfer;
  logic             out_xfer;
  logic [CNT_W-1:0] count_q, count_d;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_comb begin
    count_d = count_q;
    if (flush_w) begin
      count_d = '0;
    end else if (in_xfer && !out_xfer) begin
      count_d = count_q + CNT_W'(1);
    end else if (out_xfer && !in_xfer) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
